// File: rtl/alsu_result_fifo.sv
// Show-ahead result FIFO behind the ALSU with saturating result/error/drop counters.
// Optional build macro ALSU_RESULT_ERR_FILTER_EN keeps invalid-operation results out of the FIFO.
module alsu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [5:0]               alu_out,
  input  logic [15:0]              alu_leds,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_data,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         res_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [6:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] rd_next_s;
  logic [LW-1:0] level_next_s;
  logic          in_err_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic [6:0]    entry_s;
  logic [6:0]    head_next_s;

  // Handshake decode, next level and next head (forwarding a write into the head slot).
  always_comb begin
    in_err_s     = |alu_leds;
    pop_s        = out_valid && out_ready;
`ifdef ALSU_RESULT_ERR_FILTER_EN
    push_s       = in_valid && !in_err_s && (!full || pop_s);
    drop_s       = in_valid && !in_err_s && full && !pop_s;
    entry_s      = {1'b0, alu_out};
`else
    push_s       = in_valid && (!full || pop_s);
    drop_s       = in_valid && full && !pop_s;
    entry_s      = {in_err_s, alu_out};
`endif
    rd_next_s    = pop_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
    head_next_s  = (push_s && (wr_ptr_r == rd_next_s)) ? entry_s : mem_r[rd_next_s];
    case ({push_s, pop_s})
      2'b10:   level_next_s = level + LW'(1);
      2'b01:   level_next_s = level - LW'(1);
      default: level_next_s = level;
    endcase
  end

  // Storage array; intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Pointers, occupancy flags, registered head and statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 6'd0;
      out_err   <= 1'b0;
      res_cnt   <= '0;
      err_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
        res_cnt  <= sat_inc(res_cnt);
      end
      if (in_valid && in_err_s) begin
        err_cnt <= sat_inc(err_cnt);
      end
      if (drop_s) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      rd_ptr_r  <= rd_next_s;
      level     <= level_next_s;
      full      <= (level_next_s == LW'(DEPTH));
      empty     <= (level_next_s == LW'(0));
      out_valid <= (level_next_s != LW'(0));
      out_data  <= head_next_s[5:0];
`ifdef ALSU_RESULT_ERR_FILTER_EN
      out_err   <= 1'b0;
`else
      out_err   <= head_next_s[6];
`endif
    end
  end

endmodule

// File: tb/tb_alsu_result_fifo.sv
// Directed self-checking bench for alsu_result_fifo (DEPTH=8, CNT_W=8).
module tb_alsu_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  alu_out;
  logic [15:0] alu_leds;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_data;
  logic        out_err;
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic [7:0]  res_cnt;
  logic [7:0]  err_cnt;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;
  int exp_res;
  logic [5:0] exp_q [$];
  logic [5:0] d;

  alsu_result_fifo #(.DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_out(alu_out), .alu_leds(alu_leds),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .level(level), .full(full), .empty(empty),
    .res_cnt(res_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_err"}, 32'(out_err), 32'd0);
    chk({tag, "_res"}, 32'(res_cnt), 32'd0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; alu_out = 6'd0; alu_leds = 16'd0; out_ready = 1'b0;
    tick();
    in_valid = 1'b1; alu_out = 6'h11;
    tick();
    chk_reset_state("reset");

    // Idle after reset release
    rst = 1'b1; in_valid = 1'b0;
    tick(); tick(); tick();
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_res", 32'(res_cnt), 32'd0);

    // Three pushes, then in-order drain
    in_valid = 1'b1; alu_out = 6'h15;
    tick();
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_data", 32'(out_data), 32'h15);
    chk("p1_level", 32'(level), 32'd1);
    alu_out = 6'h2A; tick();
    alu_out = 6'h3F; tick();
    in_valid = 1'b0;
    chk("p3_level", 32'(level), 32'd3);
    chk("p3_res", 32'(res_cnt), 32'd3);
    chk("p3_head", 32'(out_data), 32'h15);
    out_ready = 1'b1;
    tick();
    chk("rd1_level", 32'(level), 32'd2);
    chk("rd1_data", 32'(out_data), 32'h2A);
    tick();
    chk("rd2_level", 32'(level), 32'd1);
    chk("rd2_data", 32'(out_data), 32'h3F);
    tick();
    chk("rd3_level", 32'(level), 32'd0);
    chk("rd3_empty", 32'(empty), 32'd1);
    chk("rd3_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    tick();
    chk("rdy_empty_level", 32'(level), 32'd0);

    // Fill to DEPTH, then overflow with and without a simultaneous pop
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alu_out = 6'(8'h20 + i);
      tick();
    end
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    alu_out = 6'h01;
    tick();
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_res", 32'(res_cnt), 32'd11);
    alu_out = 6'h02; out_ready = 1'b1;
    tick();
    chk("fullpop_level", 32'(level), 32'd8);
    chk("fullpop_drop", 32'(drop_cnt), 32'd1);
    chk("fullpop_res", 32'(res_cnt), 32'd12);
    chk("fullpop_full", 32'(full), 32'd1);
    in_valid = 1'b0;
    for (int i = 1; i < 8; i++) exp_q.push_back(6'(8'h20 + i));
    exp_q.push_back(6'h02);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(out_data), 32'(exp_q[i]));
      tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Invalid-operation result
    in_valid = 1'b1; alu_out = 6'h00; alu_leds = 16'hFFFF;
    tick();
    in_valid = 1'b0; alu_leds = 16'h0000;
    chk("err_cnt", 32'(err_cnt), 32'd1);
`ifdef ALSU_RESULT_ERR_FILTER_EN
    chk("err_filt_level", 32'(level), 32'd0);
    chk("err_filt_res", 32'(res_cnt), 32'd12);
    exp_res = 12;
`else
    chk("err_valid", 32'(out_valid), 32'd1);
    chk("err_flag", 32'(out_err), 32'd1);
    chk("err_data", 32'(out_data), 32'h00);
    chk("err_res", 32'(res_cnt), 32'd13);
    exp_res = 13;
    out_ready = 1'b1;
    tick();
    chk("err_pop_empty", 32'(empty), 32'd1);
`endif
    chk("err_drop", 32'(drop_cnt), 32'd1);

    // 260 pushes with continuous pop: saturation, wrap and order
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      d = 6'(i * 7 + 3);
      alu_out = d;
      tick();
      exp_res = (exp_res < 255) ? exp_res + 1 : 255;
      chk("stream_data", 32'(out_data), 32'(d));
      chk("stream_level", 32'(level), 32'd1);
    end
    chk("sat_res", 32'(res_cnt), 32'(exp_res));
    chk("sat_res_255", 32'(res_cnt), 32'd255);
    chk("sat_err", 32'(err_cnt), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("stream_empty", 32'(empty), 32'd1);

    // Reset mid-stream at level 5
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alu_out = 6'(i + 9);
      tick();
    end
    chk("pre_rst_level", 32'(level), 32'd5);
    rst = 1'b0;
    tick();
    chk_reset_state("midrst");
    rst = 1'b1; in_valid = 1'b0;
    tick();
    chk("post_rst_level", 32'(level), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
